// File: rtl/rgb_mixer_multi.sv
// Multi-channel quadrature encoder to PWM mixer: synchronise, debounce and decode each
// encoder into a level, then drive per-channel PWM from a shared period counter.
module rgb_mixer_multi #(
  parameter int CHANNELS     = 3,
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_DIV = 256,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic [CHANNELS-1:0]         enc_a,
  input  logic [CHANNELS-1:0]         enc_b,
  input  logic                        wrap,
  input  logic                        load,
  input  logic [CH_W-1:0]             load_ch,
  input  logic [WIDTH-1:0]            load_value,
  output logic [CHANNELS*WIDTH-1:0]   level,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        sync
);

  localparam int              PW       = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(DEBOUNCE_DIV - 1);
  localparam logic [WIDTH-1:0] LVL_MAX = '1;

  logic [CHANNELS-1:0] a_meta, a_sync, b_meta, b_sync;
  logic [CHANNELS-1:0] deb_a, deb_b, deb_a_q;
  logic [2:0]          hist_a [CHANNELS];
  logic [2:0]          hist_b [CHANNELS];
  logic [2:0]          hist_a_nxt [CHANNELS];
  logic [2:0]          hist_b_nxt [CHANNELS];
  logic [PW-1:0]       presc;
  logic                strobe;
  logic [CHANNELS-1:0] a_rise, inc, dec;

  logic [WIDTH-1:0]    level_r [CHANNELS];
  logic [WIDTH-1:0]    duty    [CHANNELS];
  logic [WIDTH-1:0]    pwm_cnt;
  logic                started;

  assign strobe = (presc == PRE_LAST);

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hist_a_nxt[i] = {hist_a[i][1:0], a_sync[i]};
      hist_b_nxt[i] = {hist_b[i][1:0], b_sync[i]};
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      a_meta  <= '0;
      a_sync  <= '0;
      b_meta  <= '0;
      b_sync  <= '0;
      deb_a   <= '0;
      deb_b   <= '0;
      deb_a_q <= '0;
      presc   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hist_a[i] <= '0;
        hist_b[i] <= '0;
      end
    end else begin
      a_meta  <= enc_a;
      a_sync  <= a_meta;
      b_meta  <= enc_b;
      b_sync  <= b_meta;
      deb_a_q <= deb_a;
      presc   <= strobe ? '0 : presc + 1'b1;
      if (strobe) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          hist_a[i] <= hist_a_nxt[i];
          hist_b[i] <= hist_b_nxt[i];
          if (hist_a_nxt[i] == 3'b111)      deb_a[i] <= 1'b1;
          else if (hist_a_nxt[i] == 3'b000) deb_a[i] <= 1'b0;
          if (hist_b_nxt[i] == 3'b111)      deb_b[i] <= 1'b1;
          else if (hist_b_nxt[i] == 3'b000) deb_b[i] <= 1'b0;
        end
      end
    end
  end

  // Only a rising debounced A counts; B selects direction.
  assign a_rise = deb_a & ~deb_a_q;
  assign inc    = a_rise & ~deb_b;
  assign dec    = a_rise & deb_b;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < CHANNELS; i++) level_r[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (load && (load_ch == CH_W'(i))) begin
          level_r[i] <= load_value;
        end else if (inc[i]) begin
          if (level_r[i] != LVL_MAX) level_r[i] <= level_r[i] + 1'b1;
          else if (wrap)             level_r[i] <= '0;
        end else if (dec[i]) begin
          if (level_r[i] != '0)      level_r[i] <= level_r[i] - 1'b1;
          else if (wrap)             level_r[i] <= LVL_MAX;
        end
      end
    end
  end

  // pwm_cnt holds at 0 for the first clock after release so that cycle carries sync
  // while sync still reads 0 during reset itself.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      started <= 1'b0;
      pwm_cnt <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else begin
      started <= 1'b1;
      if (started) pwm_cnt <= pwm_cnt + 1'b1;
      if (started && (pwm_cnt == LVL_MAX)) begin
        for (int unsigned i = 0; i < CHANNELS; i++) duty[i] <= level_r[i];
      end
    end
  end

  assign sync = started && (pwm_cnt == '0);

  always_comb begin
    level   = '0;
    pwm_out = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      level[i*WIDTH +: WIDTH] = level_r[i];
      pwm_out[i]              = (pwm_cnt < duty[i]);
    end
  end

endmodule

// File: tb/tb_rgb_mixer_multi.sv
// Self-checking bench for rgb_mixer_multi: directed scenarios plus randomized
// detents/loads checked against an arithmetic level/PWM model.
module tb_rgb_mixer_multi;
  localparam int CH  = 3;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int PER = 256;

  logic            clock = 1'b0;
  logic            resetb = 1'b0;
  logic [CH-1:0]   enc_a = '0;
  logic [CH-1:0]   enc_b = '0;
  logic            wrap = 1'b0;
  logic            load = 1'b0;
  logic [1:0]      load_ch = '0;
  logic [W-1:0]    load_value = '0;
  logic [CH*W-1:0] level;
  logic [CH-1:0]   pwm_out;
  logic            sync;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          lvl_m [CH];
  int          k;

  rgb_mixer_multi #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEBOUNCE_DIV(DIV)
  ) dut (
    .clock(clock),
    .resetb(resetb),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .wrap(wrap),
    .load(load),
    .load_ch(load_ch),
    .load_value(load_value),
    .level(level),
    .pwm_out(pwm_out),
    .sync(sync)
  );

  always #5 clock = ~clock;

  // Clock edges seen since reset release; edge 1 is period position 0.
  always @(posedge clock or negedge resetb) begin
    if (!resetb) k <= 0;
    else         k <= k + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lvl_of(input int i);
    return int'(level[i*W +: W]);
  endfunction

  function automatic int step_level(input int v, input int d, input bit w);
    int r;
    r = v + d;
    if (w)            r = ((r % PER) + PER) % PER;
    else if (r < 0)   r = 0;
    else if (r >= PER) r = PER - 1;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_levels(input string tag);
    for (int i = 0; i < CH; i++) check_val($sformatf("%s_lvl%0d", tag, i), lvl_of(i), lvl_m[i]);
  endtask

  task automatic detent(input int ch, input bit ccw);
    enc_b[ch] = ccw;
    tick(16);
    enc_a[ch] = 1'b1;
    tick(16);
    enc_a[ch] = 1'b0;
    tick(16);
    enc_b[ch] = 1'b0;
    tick(16);
    lvl_m[ch] = step_level(lvl_m[ch], ccw ? -1 : 1, wrap);
  endtask

  task automatic apply_load(input int ch, input int val);
    load = 1'b1;
    load_ch = 2'(ch);
    load_value = W'(val);
    tick(1);
    load = 1'b0;
    if (ch < CH) lvl_m[ch] = val;
  endtask

  task automatic wait_sync();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2 * PER + 50 && !found; c++) begin
      if (sync) found = 1'b1;
      else      tick(1);
    end
    if (!found) check_val("sync_timeout", 0, 1);
  endtask

  // One full period with stable levels: sync once at its start, each output high
  // for exactly the first lvl_m[i] clocks.
  task automatic check_period(input string tag);
    int hi [CH];
    int bad [CH];
    int syncs;
    tick(2);
    wait_sync();
    syncs = 0;
    for (int i = 0; i < CH; i++) begin
      hi[i] = 0;
      bad[i] = 0;
    end
    for (int p = 0; p < PER; p++) begin
      if (sync) syncs++;
      for (int i = 0; i < CH; i++) begin
        if (pwm_out[i]) hi[i]++;
        if (pwm_out[i] != (p < lvl_m[i])) bad[i]++;
      end
      tick(1);
    end
    check_val({tag, "_sync_count"}, syncs, 1);
    for (int i = 0; i < CH; i++) begin
      check_val($sformatf("%s_pwm%0d_high", tag, i), hi[i], lvl_m[i]);
      check_val($sformatf("%s_pwm%0d_shape", tag, i), bad[i], 0);
    end
  endtask

  // After release with all levels 0: sync on every 256th clock from the first, no PWM.
  task automatic check_after_release(input string tag);
    int sync_bad;
    int pwm_bad;
    sync_bad = 0;
    pwm_bad = 0;
    for (int c = 0; c < 2 * PER + 40; c++) begin
      tick(1);
      if (sync != (((k - 1) % PER) == 0)) sync_bad++;
      if (pwm_out != '0) pwm_bad++;
    end
    check_val({tag, "_sync_cadence"}, sync_bad, 0);
    check_val({tag, "_pwm_zero"}, pwm_bad, 0);
  endtask

  initial begin
    int old;
    int hi;
    int bad_val;
    int saved [CH];

    for (int i = 0; i < CH; i++) lvl_m[i] = 0;

    // Reset with encoders toggling
    resetb = 1'b0;
    for (int c = 0; c < 20; c++) begin
      enc_a = CH'($urandom);
      enc_b = CH'($urandom);
      tick(1);
      if (c == 19) begin
        check_val("rst_level", int'(level), 0);
        check_val("rst_pwm", int'(pwm_out), 0);
        check_val("rst_sync", int'(sync), 0);
      end
    end
    enc_a = '0;
    enc_b = '0;
    tick(2);
    resetb = 1'b1;
    tick(1);
    check_val("first_sync", int'(sync), 1);
    check_after_release("rel");
    check_levels("rel");

    // CW detents on ch0
    for (int d = 0; d < 5; d++) detent(0, 1'b0);
    check_levels("cw5");
    check_period("cw5");

    // Saturate then wrap at 0 on ch1
    wrap = 1'b0;
    for (int d = 0; d < 3; d++) detent(1, 1'b1);
    check_levels("sat0");
    wrap = 1'b1;
    detent(1, 1'b1);
    check_levels("wrap0");
    check_period("wrap0");

    // Load mid-period on ch2
    apply_load(2, 150);
    tick(2);
    wait_sync();
    old = lvl_m[2];
    tick(100);
    apply_load(2, 200);
    check_val("load_next_cycle", lvl_of(2), 200);
    hi = 0;
    for (int p = 101; p < PER; p++) begin
      if (pwm_out[2]) hi++;
      tick(1);
    end
    check_val("load_cur_period_high", hi, (old > 101) ? old - 101 : 0);
    check_val("load_new_period_sync", int'(sync), 1);
    hi = 0;
    for (int p = 0; p < PER; p++) begin
      if (pwm_out[2]) hi++;
      tick(1);
    end
    check_val("load_new_period_high", hi, 200);
    for (int i = 0; i < CH; i++) saved[i] = lvl_m[i];
    apply_load(3, 99);
    tick(1);
    for (int i = 0; i < CH; i++) check_val($sformatf("bad_ch_lvl%0d", i), lvl_of(i), saved[i]);

    // Glitch rejection
    enc_a[0] = 1'b1;
    tick(8);
    enc_a[0] = 1'b0;
    tick(30);
    check_levels("glitch");

    // Load held across a CW event: every cycle must show the loaded value
    enc_b[0] = 1'b0;
    tick(16);
    load = 1'b1;
    load_ch = 2'd0;
    load_value = W'(7);
    tick(1);
    enc_a[0] = 1'b1;
    bad_val = 7;
    for (int c = 0; c < 40; c++) begin
      if (lvl_of(0) != 7 && bad_val == 7) bad_val = lvl_of(0);
      tick(1);
    end
    load = 1'b0;
    lvl_m[0] = 7;
    check_val("prio_load_wins", bad_val, 7);
    enc_a[0] = 1'b0;
    tick(32);
    check_levels("prio");

    // Randomized detents and loads
    for (int op = 0; op < 24; op++) begin
      if ($urandom_range(0, 2) == 0) begin
        apply_load($urandom_range(0, 3), $urandom_range(0, PER - 1));
        tick(1);
      end else begin
        wrap = 1'($urandom);
        detent($urandom_range(0, CH - 1), 1'($urandom));
      end
      check_levels($sformatf("rnd%0d", op));
      if (op % 8 == 7) check_period($sformatf("rnd%0d", op));
    end

    // Reset mid-operation
    apply_load(0, 5);
    apply_load(1, 255);
    apply_load(2, 200);
    check_period("pre_rst");
    tick(50);
    #2 resetb = 1'b0;
    #1;
    check_val("midrst_level", int'(level), 0);
    check_val("midrst_pwm", int'(pwm_out), 0);
    check_val("midrst_sync", int'(sync), 0);
    tick(3);
    resetb = 1'b1;
    for (int i = 0; i < CH; i++) lvl_m[i] = 0;
    check_after_release("midrst");
    check_levels("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
